regfile_ctrl: RTL and testbench

Synchronous-read 32×32 register file that answers the two-read/one-write port protocol driven by the register-file test bench and by the CPU datapath. After every reset it runs a hardware clear sweep that zeroes registers 1–31, then accepts writes through a ready-qualified write port. Register 0 is hardwired to zero. Reads return data one cycle after the address is sampled.

---
 rtl/regfile_pkg.sv | 22 ++
 rtl/regfile_wdecoder.sv | 32 +++
 rtl/regfile_ctrl.sv | 197 +++++++++++++++++++
 tb/tb_regfile_ctrl.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// -----------------------------------------------------------------------------
// regfile_pkg
// Shared definitions for the regfile_ctrl slice: default widths, register
// count, the sweep FSM state type and the hardwired-zero register index.
// No ports (package).
// -----------------------------------------------------------------------------
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NUM_REGS   = 1 << ADDR_W_DEF;

    // Register 0 always reads as zero and silently discards writes.
    localparam int ZERO_REG   = 0;

    // CLEAR: post-reset zeroing sweep, RUN: normal read/write operation.
    typedef enum logic [0:0] {
        CLEAR = 1'b0,
        RUN   = 1'b1
    } state_t;

endpackage

// File: rtl/regfile_wdecoder.sv
// -----------------------------------------------------------------------------
// regfile_wdecoder
// One-hot write-enable decoder for the register array. Bit 0 is always low
// so register 0 can never be written.
// Ports:
//   addr  in  ADDR_W      register address to enable
//   en    in  1           decoder enable; all outputs low when 0
//   sel   out 2^ADDR_W    one-hot write select (bit 0 forced to 0)
// -----------------------------------------------------------------------------
module regfile_wdecoder
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NREGS  = 1 << ADDR_W
) (
    input  logic [ADDR_W-1:0] addr,
    input  logic              en,
    output logic [NREGS-1:0]  sel
);

    // Decode the address to a single enable bit, suppressing register 0.
    always_comb begin
        sel = '0;
        if (en) begin
            sel[addr] = 1'b1;
        end else begin
            sel = '0;
        end
        sel[ZERO_REG] = 1'b0;
    end

endmodule

// File: rtl/regfile_ctrl.sv
// -----------------------------------------------------------------------------
// regfile_ctrl
// 2^ADDR_W x DATA_W register file with two registered read ports and one
// ready-qualified write port. After every reset a hardware sweep zeroes
// registers 1..2^ADDR_W-1 (state CLEAR); writes are then accepted (state RUN).
// Register 0 is hardwired to zero.
//
// Build option:
//   REGFILE_CTRL_FWD_EN  defined   -> a read of the address being written on
//                                     the same edge returns WriteData
//                                     (write-through forwarding).
//                        undefined -> read-before-write; the new value is
//                                     visible from the following edge.
//
// Ports:
//   Clk            in   1       clock, rising edge
//   Reset_n        in   1       synchronous active-low reset
//   ReadRegister1  in   ADDR_W  read port 1 address
//   ReadRegister2  in   ADDR_W  read port 2 address
//   ReadData1      out  DATA_W  read port 1 data (registered)
//   ReadData2      out  DATA_W  read port 2 data (registered)
//   WriteRegister  in   ADDR_W  write address
//   WriteData      in   DATA_W  write data
//   RegWrite       in   1       write request (dropped unless WriteReady)
//   WriteReady     out  1       write port accepting (state == RUN)
//   Busy           out  1       clear sweep in progress (state == CLEAR)
//   ReadValid      out  1       read data reflects a post-clear read
// -----------------------------------------------------------------------------
module regfile_ctrl
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              Clk,
    input  logic              Reset_n,
    input  logic [ADDR_W-1:0] ReadRegister1,
    input  logic [ADDR_W-1:0] ReadRegister2,
    output logic [DATA_W-1:0] ReadData1,
    output logic [DATA_W-1:0] ReadData2,
    input  logic [ADDR_W-1:0] WriteRegister,
    input  logic [DATA_W-1:0] WriteData,
    input  logic              RegWrite,
    output logic              WriteReady,
    output logic              Busy,
    output logic              ReadValid
);

    localparam int                NREGS     = 1 << ADDR_W;
    localparam logic [ADDR_W-1:0] ZERO_ADDR = ADDR_W'(ZERO_REG);
    localparam logic [ADDR_W-1:0] FIRST_IDX = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W-1:0] LAST_IDX  = {ADDR_W{1'b1}};

    state_t              state_r;
    logic [ADDR_W-1:0]   idx_r;
    logic [DATA_W-1:0]   rd1_r;
    logic [DATA_W-1:0]   rd2_r;
    logic                valid_r;
    logic                ready_r;
    logic                busy_r;

    // Register 0 storage is never written; reads of address 0 bypass it.
    logic [DATA_W-1:0]   mem_r [NREGS];

    logic [ADDR_W-1:0]   wr_addr_s;
    logic [DATA_W-1:0]   wr_data_s;
    logic                wr_en_s;
    logic [NREGS-1:0]    wr_sel_s;
    logic [DATA_W-1:0]   rd1_s;
    logic [DATA_W-1:0]   rd2_s;
`ifdef REGFILE_CTRL_FWD_EN
    logic                wr_acc_s;
`endif

    // Write-port source: the sweep owns the array in CLEAR, the user port in RUN.
    always_comb begin
        wr_addr_s = WriteRegister;
        wr_data_s = WriteData;
        wr_en_s   = 1'b0;
        if (!Reset_n) begin
            wr_en_s = 1'b0;
        end else if (state_r == CLEAR) begin
            wr_addr_s = idx_r;
            wr_data_s = '0;
            wr_en_s   = 1'b1;
        end else begin
            wr_en_s = RegWrite;
        end
    end

    regfile_wdecoder #(
        .ADDR_W (ADDR_W),
        .NREGS  (NREGS)
    ) u_wdecoder (
        .addr (wr_addr_s),
        .en   (wr_en_s),
        .sel  (wr_sel_s)
    );

    // Register array update; contents are defined only by the sweep, never by reset.
    always_ff @(posedge Clk) begin
        for (int i = 0; i < NREGS; i++) begin
            if (wr_sel_s[i]) begin
                mem_r[i] <= wr_data_s;
            end
        end
    end

`ifdef REGFILE_CTRL_FWD_EN
    // A user write that will land in the array on this edge (nonzero address).
    always_comb begin
        wr_acc_s = Reset_n && (state_r == RUN) && RegWrite &&
                   (WriteRegister != ZERO_ADDR);
    end
`endif

    // Read port 1 data select: zero register, optional forward, else array.
    always_comb begin
        rd1_s = '0;
        if (ReadRegister1 == ZERO_ADDR) begin
            rd1_s = '0;
        end
`ifdef REGFILE_CTRL_FWD_EN
        else if (wr_acc_s && (WriteRegister == ReadRegister1)) begin
            rd1_s = WriteData;
        end
`endif
        else begin
            rd1_s = mem_r[ReadRegister1];
        end
    end

    // Read port 2 data select: zero register, optional forward, else array.
    always_comb begin
        rd2_s = '0;
        if (ReadRegister2 == ZERO_ADDR) begin
            rd2_s = '0;
        end
`ifdef REGFILE_CTRL_FWD_EN
        else if (wr_acc_s && (WriteRegister == ReadRegister2)) begin
            rd2_s = WriteData;
        end
`endif
        else begin
            rd2_s = mem_r[ReadRegister2];
        end
    end

    // Sweep FSM with registered read data and status outputs.
    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state_r <= CLEAR;
            idx_r   <= FIRST_IDX;
            rd1_r   <= '0;
            rd2_r   <= '0;
            valid_r <= 1'b0;
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
        end else begin
            rd1_r <= rd1_s;
            rd2_r <= rd2_s;
            case (state_r)
                CLEAR: begin
                    valid_r <= 1'b0;
                    // Hold the index at the top; it must never wrap to 0.
                    if (idx_r == LAST_IDX) begin
                        state_r <= RUN;
                        ready_r <= 1'b1;
                        busy_r  <= 1'b0;
                    end else begin
                        idx_r <= idx_r + FIRST_IDX;
                    end
                end
                RUN: begin
                    // First edge spent in RUN samples fully cleared data.
                    valid_r <= 1'b1;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
                default: begin
                    state_r <= CLEAR;
                    idx_r   <= FIRST_IDX;
                    valid_r <= 1'b0;
                    ready_r <= 1'b0;
                    busy_r  <= 1'b1;
                end
            endcase
        end
    end

    assign ReadData1  = rd1_r;
    assign ReadData2  = rd2_r;
    assign ReadValid  = valid_r;
    assign WriteReady = ready_r;
    assign Busy       = busy_r;

endmodule

// File: tb/tb_regfile_ctrl.sv
// -----------------------------------------------------------------------------
// tb_regfile_ctrl
// Scoreboard bench for regfile_ctrl. Each driven cycle computes the expected
// read data and status from a behavioural model, pushes it into a queue, and
// pops/compares it after the clock edge that produces the outputs.
// -----------------------------------------------------------------------------
module tb_regfile_ctrl;

`ifdef REGFILE_CTRL_FWD_EN
    localparam bit FWD = 1'b1;
`else
    localparam bit FWD = 1'b0;
`endif

    logic        Clk;
    logic        Reset_n;
    logic [4:0]  ReadRegister1;
    logic [4:0]  ReadRegister2;
    logic [31:0] ReadData1;
    logic [31:0] ReadData2;
    logic [4:0]  WriteRegister;
    logic [31:0] WriteData;
    logic        RegWrite;
    logic        WriteReady;
    logic        Busy;
    logic        ReadValid;

    regfile_ctrl #(
        .DATA_W (32),
        .ADDR_W (5)
    ) dut (
        .Clk           (Clk),
        .Reset_n       (Reset_n),
        .ReadRegister1 (ReadRegister1),
        .ReadRegister2 (ReadRegister2),
        .ReadData1     (ReadData1),
        .ReadData2     (ReadData2),
        .WriteRegister (WriteRegister),
        .WriteData     (WriteData),
        .RegWrite      (RegWrite),
        .WriteReady    (WriteReady),
        .Busy          (Busy),
        .ReadValid     (ReadValid)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    typedef struct {
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic        valid;
        logic        busy;
        logic        ready;
        bit          chk_data;
    } exp_t;

    exp_t        sb_q [$];
    logic [31:0] model_q [32];
    int          sweep_cnt;
    bit          valid_m;
    int          check_cnt;
    int          err_cnt;

    task automatic check_val(input string tag, input logic [31:0] act,
                             input logic [31:0] exp);
        check_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    function automatic logic [31:0] rd_exp(input logic [4:0] ra,
                                           input logic [4:0] wa,
                                           input logic [31:0] wd,
                                           input bit acc);
        if (ra == 5'd0) return 32'd0;
        if (FWD && acc && (wa == ra)) return wd;
        return model_q[ra];
    endfunction

    task automatic compare(input string tag);
        exp_t e;
        if (sb_q.size() == 0) begin
            check_val({tag, "_sb_empty"}, 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            if (e.chk_data) begin
                check_val({tag, "_rd1"}, ReadData1, e.rd1);
                check_val({tag, "_rd2"}, ReadData2, e.rd2);
            end
            check_val({tag, "_valid"}, {31'd0, ReadValid},  {31'd0, e.valid});
            check_val({tag, "_busy"},  {31'd0, Busy},       {31'd0, e.busy});
            check_val({tag, "_ready"}, {31'd0, WriteReady}, {31'd0, e.ready});
        end
    endtask

    // One clock cycle of stimulus with model update and scoreboard check.
    task automatic cyc(input string tag, input logic [4:0] ra1,
                       input logic [4:0] ra2, input logic [4:0] wa,
                       input logic [31:0] wd, input logic we);
        exp_t e;
        bit   run_m;
        bit   acc;
        ReadRegister1 = ra1;
        ReadRegister2 = ra2;
        WriteRegister = wa;
        WriteData     = wd;
        RegWrite      = we;
        run_m = (sweep_cnt >= 31);
        acc   = run_m && we && (wa != 5'd0);
        e.rd1 = rd_exp(ra1, wa, wd, acc);
        e.rd2 = rd_exp(ra2, wa, wd, acc);
        e.chk_data = run_m;
        if (!run_m) begin
            model_q[sweep_cnt + 1] = 32'd0;
            sweep_cnt++;
        end else begin
            valid_m = 1'b1;
            if (acc) model_q[wa] = wd;
        end
        e.valid = valid_m;
        e.ready = (sweep_cnt >= 31);
        e.busy  = !e.ready;
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        compare(tag);
    endtask

    // One edge with Reset_n low; the sweep then restarts from register 1.
    task automatic do_reset(input string tag);
        exp_t e;
        Reset_n  = 1'b0;
        RegWrite = 1'b0;
        e.rd1 = 32'd0;
        e.rd2 = 32'd0;
        e.valid = 1'b0;
        e.busy  = 1'b1;
        e.ready = 1'b0;
        e.chk_data = 1'b1;
        sweep_cnt = 0;
        valid_m   = 1'b0;
        sb_q.push_back(e);
        @(posedge Clk);
        #1;
        compare(tag);
        Reset_n = 1'b1;
    endtask

    initial begin
        check_cnt = 0;
        err_cnt   = 0;
        sweep_cnt = 0;
        valid_m   = 1'b0;
        for (int i = 0; i < 32; i++) model_q[i] = 32'd0;
        Reset_n       = 1'b0;
        ReadRegister1 = 5'd0;
        ReadRegister2 = 5'd0;
        WriteRegister = 5'd0;
        WriteData     = 32'd0;
        RegWrite      = 1'b0;
        #1;

        do_reset("rst0");
        do_reset("rst1");

        // Sweep: 31 busy edges; a write of 7 to reg 5 mid-sweep must be dropped.
        for (int k = 0; k < 31; k++) begin
            if (k == 3) cyc("sweep_wr", 5'd5, 5'd5, 5'd5, 32'd7, 1'b1);
            else        cyc("sweep", 5'd0, 5'd0, 5'd0, 32'd0, 1'b0);
        end

        // All registers read back zero after the sweep.
        for (int i = 1; i < 32; i++) begin
            cyc("clr_rd", 5'(i), 5'(32 - i), 5'd0, 32'd0, 1'b0);
        end

        cyc("wr42",    5'd0, 5'd0, 5'd2, 32'd42, 1'b1);
        cyc("rd42",    5'd2, 5'd2, 5'd0, 32'd0,  1'b0);
        cyc("wr15",    5'd0, 5'd0, 5'd2, 32'd15, 1'b1);
        cyc("rd15",    5'd2, 5'd2, 5'd0, 32'd0,  1'b0);
        cyc("nowr16",  5'd0, 5'd0, 5'd2, 32'd16, 1'b0);
        cyc("rd15b",   5'd2, 5'd2, 5'd0, 32'd0,  1'b0);
        cyc("wr24",    5'd0, 5'd0, 5'd2, 32'd24, 1'b1);
        cyc("rd24_4",  5'd2, 5'd4, 5'd0, 32'd0,  1'b0);
        cyc("wr0",     5'd0, 5'd0, 5'd0, 32'd3,  1'b1);
        cyc("rd0_5",   5'd0, 5'd5, 5'd0, 32'd0,  1'b0);
        cyc("same_e",  5'd2, 5'd2, 5'd2, 32'd6,  1'b1);
        cyc("same_n",  5'd2, 5'd2, 5'd0, 32'd0,  1'b0);

        // Random traffic on a narrow address range to provoke collisions.
        for (int k = 0; k < 80; k++) begin
            cyc("rand", 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                5'($urandom_range(0, 7)), $urandom, 1'($urandom_range(0, 1)));
        end

        // Mid-RUN reset wipes reg 9 through the restarted sweep.
        cyc("wr99",    5'd0, 5'd0, 5'd9, 32'd99, 1'b1);
        cyc("rd99",    5'd9, 5'd9, 5'd0, 32'd0,  1'b0);
        do_reset("rst_mid");
        for (int k = 0; k < 31; k++) begin
            cyc("sweep2", 5'd9, 5'd9, 5'd9, 32'd5, 1'b1);
        end
        cyc("rd9_clr", 5'd9, 5'd9, 5'd0, 32'd0, 1'b0);
        cyc("rd9_chk", 5'd9, 5'd2, 5'd0, 32'd0, 1'b0);

        check_val("sb_drain", 32'(sb_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", check_cnt, err_cnt);
        $finish;
    end

endmodule
